// File: rtl/trap_ctrl.sv
// Machine-mode trap/mret sequencer: on an exception or mret in ID it stalls the
// pipeline, writes the trap CSRs one per cycle, then issues a one-cycle PC redirect.
// Optional feature macro: TRAP_MTVAL_EN adds the mtval write (TVAL state + tval latch).
module trap_ctrl #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            instr_valid_i,
  input  logic            id_ilegl_instr_i,
  input  logic            id_ecall_i,
  input  logic            id_ebreak_i,
  input  logic            id_mret_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] csr_mtvec_i,
  input  logic [XLEN-1:0] csr_mepc_i,
  input  logic [XLEN-1:0] csr_mstatus_i,
  output logic            stall_o,
  output logic            flush_o,
  output logic            csr_we_o,
  output logic [11:0]     csr_waddr_o,
  output logic [XLEN-1:0] csr_wdata_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            busy_o
);

  typedef enum logic [2:0] {
    StIdle,
    StEpc,
    StCause,
`ifdef TRAP_MTVAL_EN
    StTval,
`endif
    StStatus,
    StMretSt,
    StRedir
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [3:0]      cause_q, cause_d;
  logic            mret_q, mret_d;
`ifdef TRAP_MTVAL_EN
  logic [XLEN-1:0] tval_q, tval_d;
`endif

  logic            trap_flag;
  logic            evt;
  logic            in_idle;
  logic            accept;
  logic [XLEN-1:0] mstatus_trap;
  logic [XLEN-1:0] mstatus_mret;

  assign trap_flag = id_ilegl_instr_i | id_ecall_i | id_ebreak_i;
  assign evt       = instr_valid_i & (trap_flag | id_mret_i);
  assign in_idle   = (state_q == StIdle);
  assign accept    = evt & in_idle;

  // Reset gating keeps stall/flush low while rst_n_i is asserted.
  assign flush_o = accept & rst_n_i;
  assign stall_o = (evt | ~in_idle) & rst_n_i;
  assign busy_o  = ~in_idle;

  // Sequence next-state and capture of the trapping instruction's context.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cause_d = cause_q;
    mret_d  = mret_q;
`ifdef TRAP_MTVAL_EN
    tval_d  = tval_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept && trap_flag) begin
          state_d = StEpc;
          pc_d    = pc_i;
          mret_d  = 1'b0;
          // Priority illegal > ecall > ebreak.
          if (id_ilegl_instr_i)  cause_d = 4'd2;
          else if (id_ecall_i)   cause_d = 4'd11;
          else                   cause_d = 4'd3;
`ifdef TRAP_MTVAL_EN
          if (id_ilegl_instr_i)  tval_d = XLEN'(instr_i);
          else if (id_ecall_i)   tval_d = '0;
          else                   tval_d = pc_i;
`endif
        end else if (accept) begin
          state_d = StMretSt;
          mret_d  = 1'b1;
        end
      end
      StEpc:    state_d = StCause;
`ifdef TRAP_MTVAL_EN
      StCause:  state_d = StTval;
      StTval:   state_d = StStatus;
`else
      StCause:  state_d = StStatus;
`endif
      StStatus: state_d = StRedir;
      StMretSt: state_d = StRedir;
      StRedir:  state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // State and context registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= StIdle;
      pc_q    <= '0;
      cause_q <= '0;
      mret_q  <= 1'b0;
`ifdef TRAP_MTVAL_EN
      tval_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
      mret_q  <= mret_d;
`ifdef TRAP_MTVAL_EN
      tval_q  <= tval_d;
`endif
    end
  end

  // mstatus images for trap entry (MPIE<=MIE, MIE<=0) and mret (MIE<=MPIE, MPIE<=1).
  always_comb begin
    mstatus_trap        = csr_mstatus_i;
    mstatus_trap[7]     = csr_mstatus_i[3];
    mstatus_trap[3]     = 1'b0;
    mstatus_trap[12:11] = 2'b11;
    mstatus_mret        = csr_mstatus_i;
    mstatus_mret[3]     = csr_mstatus_i[7];
    mstatus_mret[7]     = 1'b1;
    mstatus_mret[12:11] = 2'b11;
  end

  // CSR write port and redirect decoded from the current state; zero when not valid.
  always_comb begin
    csr_we_o         = 1'b0;
    csr_waddr_o      = '0;
    csr_wdata_o      = '0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    unique case (state_q)
      StEpc: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = 12'h341;
        csr_wdata_o = {pc_q[XLEN-1:2], 2'b00};
      end
      StCause: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = 12'h342;
        csr_wdata_o = XLEN'(cause_q);
      end
`ifdef TRAP_MTVAL_EN
      StTval: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = 12'h343;
        csr_wdata_o = tval_q;
      end
`endif
      StStatus: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = 12'h300;
        csr_wdata_o = mstatus_trap;
      end
      StMretSt: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = 12'h300;
        csr_wdata_o = mstatus_mret;
      end
      StRedir: begin
        redirect_valid_o = 1'b1;
        // Vectored mtvec mode is treated as direct.
        redirect_pc_o    = mret_q ? csr_mepc_i : {csr_mtvec_i[XLEN-1:2], 2'b00};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed cases plus random events checked
// against a CSR-write-list reference model. Follows TRAP_MTVAL_EN like the DUT.
module tb_trap_ctrl;

  localparam int unsigned XLEN = 64;
`ifdef TRAP_MTVAL_EN
  localparam int NWTRAP = 4;
`else
  localparam int NWTRAP = 3;
`endif

  logic            clk;
  logic            rst_n;
  logic            instr_valid;
  logic            ilegl, ecall, ebreak, mret;
  logic [XLEN-1:0] pc;
  logic [31:0]     instr;
  logic [XLEN-1:0] mtvec, mepc, mstatus;
  logic            stall, flush, csr_we, redir_v, busy;
  logic [11:0]     csr_waddr;
  logic [XLEN-1:0] csr_wdata, redir_pc;

  int checks = 0;
  int errors = 0;

  trap_ctrl #(.XLEN(XLEN)) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .instr_valid_i   (instr_valid),
    .id_ilegl_instr_i(ilegl),
    .id_ecall_i      (ecall),
    .id_ebreak_i     (ebreak),
    .id_mret_i       (mret),
    .pc_i            (pc),
    .instr_i         (instr),
    .csr_mtvec_i     (mtvec),
    .csr_mepc_i      (mepc),
    .csr_mstatus_i   (mstatus),
    .stall_o         (stall),
    .flush_o         (flush),
    .csr_we_o        (csr_we),
    .csr_waddr_o     (csr_waddr),
    .csr_wdata_o     (csr_wdata),
    .redirect_valid_o(redir_v),
    .redirect_pc_o   (redir_pc),
    .busy_o          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Architectural mstatus updates, written from the bit-field rules.
  function automatic logic [63:0] trap_status(input logic [63:0] s);
    logic [63:0] r;
    r = (s & ~64'h1888) | 64'h1800;
    if (s[3]) r = r | 64'h80;
    return r;
  endfunction

  function automatic logic [63:0] mret_status(input logic [63:0] s);
    logic [63:0] r;
    r = (s & ~64'h1888) | 64'h1880;
    if (s[7]) r = r | 64'h8;
    return r;
  endfunction

  task automatic clear_flags();
    instr_valid = 1'b0; ilegl = 1'b0; ecall = 1'b0; ebreak = 1'b0; mret = 1'b0;
  endtask

  // Drive one ID-stage instruction, then compare the CSR writes and redirect
  // against the model. inject_k > 0 re-asserts ebreak during that follow-on cycle.
  task automatic run_evt(input bit v, input bit il, input bit ec, input bit eb, input bit mr,
                         input logic [63:0] p, input logic [31:0] ins, input logic [63:0] tv,
                         input logic [63:0] ep, input logic [63:0] st, input int inject_k);
    logic [11:0] ea[$];
    logic [63:0] ed[$];
    logic [11:0] oa[$];
    logic [63:0] od[$];
    logic [63:0] erpc, rpc, tval;
    logic [3:0]  cause;
    bit          ev;
    int          elat, lat, bound;
    ev   = v && (il || ec || eb || mr);
    erpc = '0;
    elat = -1;
    if (ev) begin
      if (il || ec || eb) begin
        cause = il ? 4'd2 : (ec ? 4'd11 : 4'd3);
        tval  = il ? 64'(ins) : (ec ? 64'd0 : p);
        ea.push_back(12'h341); ed.push_back(p & ~64'h3);
        ea.push_back(12'h342); ed.push_back(64'(cause));
`ifdef TRAP_MTVAL_EN
        ea.push_back(12'h343); ed.push_back(tval);
`endif
        ea.push_back(12'h300); ed.push_back(trap_status(st));
        erpc = tv & ~64'h3;
      end else begin
        ea.push_back(12'h300); ed.push_back(mret_status(st));
        erpc = ep;
      end
      elat = ea.size() + 1;
    end
    @(posedge clk); #1;
    instr_valid = v; ilegl = il; ecall = ec; ebreak = eb; mret = mr;
    pc = p; instr = ins; mtvec = tv; mepc = ep; mstatus = st;
    @(negedge clk);
    chk("flush_at_T", 64'(flush), 64'(ev));
    chk("stall_at_T", 64'(stall), 64'(ev));
    chk("busy_at_T", 64'(busy), 64'd0);
    chk("we_at_T", 64'(csr_we), 64'd0);
    lat   = -1;
    rpc   = '0;
    bound = ev ? 12 : 3;
    for (int k = 1; k <= bound; k++) begin
      @(posedge clk); #1;
      if (k == 1) clear_flags();
      if (k == inject_k) begin instr_valid = 1'b1; ebreak = 1'b1; end
      else if (k == inject_k + 1) clear_flags();
      @(negedge clk);
      chk("flush_after_T", 64'(flush), 64'd0);
      chk("busy_seq", 64'(busy), 64'(ev));
      if (csr_we) begin
        oa.push_back(csr_waddr);
        od.push_back(csr_wdata);
      end else begin
        chk("idle_wport_zero", {csr_waddr, csr_wdata[51:0]} | csr_wdata, 64'd0);
      end
      if (redir_v) begin
        lat = k;
        rpc = redir_pc;
        break;
      end else begin
        chk("idle_rpc_zero", redir_pc, 64'd0);
      end
    end
    clear_flags();
    if (lat >= 0) begin
      @(negedge clk);
      chk("redirect_one_cycle", 64'(redir_v), 64'd0);
      chk("busy_after_redir", 64'(busy), 64'd0);
    end
    chk("redirect_latency", 64'(lat), 64'(elat));
    chk("redirect_pc", rpc, erpc);
    chk("write_count", 64'(oa.size()), 64'(ea.size()));
    for (int i = 0; i < oa.size() && i < ea.size(); i++) begin
      chk("write_addr", 64'(oa[i]), 64'(ea[i]));
      chk("write_data", od[i], ed[i]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    clear_flags();
    pc = '0; instr = '0; mtvec = '0; mepc = '0; mstatus = '0;
    // Event presented while in reset must not leak to the outputs.
    instr_valid = 1'b1; ecall = 1'b1;
    #12;
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_flush", 64'(flush), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_we", 64'(csr_we), 64'd0);
    chk("rst_redir", 64'(redir_v), 64'd0);
    clear_flags();
    @(negedge clk); rst_n = 1'b1;

    // ecall with vectored-looking mtvec.
    run_evt(1, 0, 1, 0, 0, 64'h8000_0010, 32'h0000_0073, 64'h8000_0101, 64'h0, 64'h8, -1);
    // illegal wins over ecall.
    run_evt(1, 1, 1, 0, 0, 64'h8000_0020, 32'hFFFF_FFFF, 64'h8000_0101, 64'h0, 64'h8, -1);
    // mret.
    run_evt(1, 0, 0, 0, 1, 64'h8000_0300, 32'h3020_0073, 64'h8000_0101, 64'h8000_0200,
            64'h80, -1);
    // ebreak re-asserted in STATUS is ignored.
    run_evt(1, 0, 0, 1, 0, 64'h8000_0042, 32'h0010_0073, 64'h8000_1000, 64'h0, 64'h1808,
            NWTRAP);
    // Flags without instr_valid are not an event.
    run_evt(0, 1, 1, 1, 1, 64'h1234, 32'h0, 64'h4000, 64'h0, 64'h0, -1);

    // Reset in CAUSE aborts the sequence.
    @(posedge clk); #1;
    instr_valid = 1'b1; ecall = 1'b1; pc = 64'h8000_0010; mtvec = 64'h8000_0100;
    @(posedge clk); #1; clear_flags();
    @(posedge clk); #1;
    @(negedge clk);
    chk("cause_state_addr", 64'(csr_waddr), 64'h342);
    instr_valid = 1'b1; ecall = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("midrst_stall", 64'(stall), 64'd0);
    chk("midrst_flush", 64'(flush), 64'd0);
    chk("midrst_we", 64'(csr_we), 64'd0);
    chk("midrst_wdata", csr_wdata | 64'(csr_waddr), 64'd0);
    chk("midrst_redir", 64'(redir_v) | redir_pc, 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    clear_flags();
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("postrst_quiet", {61'd0, csr_we, redir_v, busy}, 64'd0);
    end

    // Random events against the model.
    for (int n = 0; n < 24; n++) begin
      logic [3:0] f;
      f = 4'($urandom_range(0, 15));
      run_evt(($urandom_range(0, 7) != 0), f[3], f[2], f[1], f[0],
              {$urandom, $urandom}, $urandom, {$urandom, $urandom}, {$urandom, $urandom},
              {$urandom, $urandom}, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
